// File: rtl/serial_adder.sv
// serial_adder: bit-serial adder built from one full-adder cell and a carry
// flip-flop. Operands are captured on the accepting edge and added LSB-first,
// one bit per clock. The WIDTH-bit sum and the carry-out are published together
// on the last RUN edge, and done pulses for one cycle after that edge.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for start_i; operands captured on the accepting edge
// RUN   | one full-adder evaluation per cycle, LSB first
// DONE  | result published; done_o high for this single cycle
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             cin_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] sum_o,
  output logic             cout_o
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sr_q, a_sr_d;
  logic [WIDTH-1:0] b_sr_q, b_sr_d;
  logic [WIDTH-1:0] sum_sr_q, sum_sr_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;

  logic fa_s;
  logic fa_c;

  // The single shared full-adder cell, fed by the operand LSBs and the carry flop.
  always_comb begin
    fa_s = a_sr_q[0] ^ b_sr_q[0] ^ carry_q;
    fa_c = (a_sr_q[0] & b_sr_q[0]) | (a_sr_q[0] & carry_q) | (b_sr_q[0] & carry_q);
  end

  // State and datapath registers; reset discards any in-flight operation.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      a_sr_q   <= '0;
      b_sr_q   <= '0;
      sum_sr_q <= '0;
      carry_q  <= 1'b0;
      cnt_q    <= '0;
      sum_q    <= '0;
      cout_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_sr_q   <= a_sr_d;
      b_sr_q   <= b_sr_d;
      sum_sr_q <= sum_sr_d;
      carry_q  <= carry_d;
      cnt_q    <= cnt_d;
      sum_q    <= sum_d;
      cout_q   <= cout_d;
    end
  end

  // Next-state and datapath update; everything holds unless the state says otherwise.
  always_comb begin
    state_d  = state_q;
    a_sr_d   = a_sr_q;
    b_sr_d   = b_sr_q;
    sum_sr_d = sum_sr_q;
    carry_d  = carry_q;
    cnt_d    = cnt_q;
    sum_d    = sum_q;
    cout_d   = cout_q;

    unique case (state_q)
      S_IDLE: begin
        if (start_i) begin
          a_sr_d   = a_i;
          b_sr_d   = b_i;
          carry_d  = cin_i;
          sum_sr_d = '0;
          cnt_d    = '0;
          state_d  = S_RUN;
        end
      end
      S_RUN: begin
        a_sr_d   = {1'b0, a_sr_q[WIDTH-1:1]};
        b_sr_d   = {1'b0, b_sr_q[WIDTH-1:1]};
        sum_sr_d = {fa_s, sum_sr_q[WIDTH-1:1]};
        carry_d  = fa_c;
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == CNT_LAST) begin
          // The final bit lands in the MSB on this same edge, so publish the
          // shifted value directly rather than waiting a cycle.
          sum_d   = {fa_s, sum_sr_q[WIDTH-1:1]};
          cout_d  = fa_c;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Outputs come straight from flops or a decode of the state flop only.
  always_comb begin
    busy_o = (state_q == S_RUN);
    done_o = (state_q == S_DONE);
    sum_o  = sum_q;
    cout_o = cout_q;
  end

endmodule

// File: tb/tb_serial_adder.sv
// Testbench for serial_adder (WIDTH=8): scenario tasks with a result scoreboard.
module tb_serial_adder;

  localparam int W = 8;

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic         start_i;
  logic [W-1:0] a_i;
  logic [W-1:0] b_i;
  logic         cin_i;
  logic         busy_o;
  logic         done_o;
  logic [W-1:0] sum_o;
  logic         cout_o;

  logic [W:0] sb_q[$];
  int checks   = 0;
  int failures = 0;

  always #5 clk_i = ~clk_i;

  serial_adder #(.WIDTH(W)) dut (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .start_i (start_i),
    .a_i     (a_i),
    .b_i     (b_i),
    .cin_i   (cin_i),
    .busy_o  (busy_o),
    .done_o  (done_o),
    .sum_o   (sum_o),
    .cout_o  (cout_o)
  );

  // Present a request for one accepting edge; optionally record the expected result.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic c, input bit push);
    @(negedge clk_i);
    a_i = a; b_i = b; cin_i = c; start_i = 1'b1;
    if (push) sb_q.push_back({1'b0, a} + {1'b0, b} + {{W{1'b0}}, c});
    @(posedge clk_i);
    #1 start_i = 1'b0;
  endtask

  // Walk cycles until done_o, counting busy cycles; optional disturbance of inputs.
  task automatic collect(input int max, input int pulse_at, input bit scramble,
                         output bit got, output int bc);
    got = 1'b0;
    bc  = 0;
    for (int i = 0; i < max; i++) begin
      @(negedge clk_i);
      if (i == pulse_at) begin
        start_i = 1'b1; a_i = 8'hAA; b_i = 8'h55;
      end else begin
        start_i = 1'b0;
      end
      if (scramble) begin
        a_i = W'($urandom); b_i = W'($urandom); cin_i = 1'($urandom);
      end
      if (done_o) begin
        got = 1'b1;
        break;
      end
      if (busy_o) bc++;
    end
  endtask

  task automatic test_reset();
    rst_i = 1'b1; start_i = 1'b0; a_i = '0; b_i = '0; cin_i = 1'b0;
    repeat (3) @(negedge clk_i);
    checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b want=0", busy_o); end
    checks++; if (done_o !== 1'b0) begin failures++; $display("FAIL reset_done got=%b want=0", done_o); end
    checks++; if ({cout_o, sum_o} !== 9'h000) begin failures++; $display("FAIL reset_result got=%h want=000", {cout_o, sum_o}); end
    rst_i = 1'b0;
  endtask

  task automatic test_basic();
    bit got; int bc; logic [W:0] exp;
    issue(8'h5A, 8'h3C, 1'b0, 1'b1);
    collect(W + 5, -1, 1'b0, got, bc);
    checks++; if (got !== 1'b1) begin failures++; $display("FAIL basic_timeout got_done=%b want=1", got); end
    checks++; if (bc != W) begin failures++; $display("FAIL basic_busy_cycles got=%0d want=%0d", bc, W); end
    exp = sb_q.pop_front();
    checks++; if ({cout_o, sum_o} !== exp) begin failures++; $display("FAIL basic_result got=%h want=%h", {cout_o, sum_o}, exp); end
    @(negedge clk_i);
    checks++; if (done_o !== 1'b0) begin failures++; $display("FAIL basic_done_width got=%b want=0", done_o); end
    checks++; if ({cout_o, sum_o} !== exp) begin failures++; $display("FAIL basic_hold got=%h want=%h", {cout_o, sum_o}, exp); end
  endtask

  task automatic test_carry();
    bit got; int bc; logic [W:0] exp;
    issue(8'hFF, 8'h01, 1'b0, 1'b1);
    collect(W + 5, -1, 1'b0, got, bc);
    exp = sb_q.pop_front();
    checks++; if (got !== 1'b1 || {cout_o, sum_o} !== exp) begin failures++; $display("FAIL carry_ff_01 got=%h done=%b want=%h", {cout_o, sum_o}, got, exp); end
    issue(8'hFF, 8'hFF, 1'b1, 1'b1);
    collect(W + 5, -1, 1'b0, got, bc);
    exp = sb_q.pop_front();
    checks++; if (got !== 1'b1 || {cout_o, sum_o} !== exp) begin failures++; $display("FAIL carry_ff_ff_1 got=%h done=%b want=%h", {cout_o, sum_o}, got, exp); end
  endtask

  task automatic test_start_while_busy();
    bit got; int bc; int extra; logic [W:0] exp;
    issue(8'h10, 8'h20, 1'b0, 1'b1);
    collect(W + 5, 2, 1'b0, got, bc);
    exp = sb_q.pop_front();
    checks++; if (got !== 1'b1 || {cout_o, sum_o} !== exp) begin failures++; $display("FAIL busy_start_result got=%h done=%b want=%h", {cout_o, sum_o}, got, exp); end
    extra = 0;
    for (int i = 0; i < 2 * W; i++) begin
      @(negedge clk_i);
      if (done_o || busy_o) extra++;
    end
    checks++; if (extra != 0) begin failures++; $display("FAIL busy_start_ignored got_active_cycles=%0d want=0", extra); end
  endtask

  task automatic test_operand_hold();
    bit got; int bc; logic [W:0] exp;
    issue(8'h0F, 8'hF0, 1'b1, 1'b1);
    collect(W + 5, -1, 1'b1, got, bc);
    exp = sb_q.pop_front();
    checks++; if (got !== 1'b1 || {cout_o, sum_o} !== exp) begin failures++; $display("FAIL operand_hold got=%h done=%b want=%h", {cout_o, sum_o}, got, exp); end
    a_i = '0; b_i = '0; cin_i = 1'b0;
  endtask

  task automatic test_reset_mid();
    bit got; int bc; int dn; logic [W:0] exp;
    issue(8'h77, 8'h11, 1'b0, 1'b0);
    repeat (3) @(negedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b1;
    @(posedge clk_i);
    #1 rst_i = 1'b0;
    @(negedge clk_i);
    checks++; if (busy_o !== 1'b0 || done_o !== 1'b0) begin failures++; $display("FAIL midrst_flags got_busy=%b got_done=%b want=0,0", busy_o, done_o); end
    checks++; if ({cout_o, sum_o} !== 9'h000) begin failures++; $display("FAIL midrst_result got=%h want=000", {cout_o, sum_o}); end
    dn = 0;
    for (int i = 0; i < W + 3; i++) begin
      @(negedge clk_i);
      if (done_o) dn++;
    end
    checks++; if (dn != 0) begin failures++; $display("FAIL midrst_no_done got=%0d want=0", dn); end
    issue(8'h01, 8'h01, 1'b0, 1'b1);
    collect(W + 5, -1, 1'b0, got, bc);
    exp = sb_q.pop_front();
    checks++; if (got !== 1'b1 || bc != W || {cout_o, sum_o} !== exp) begin failures++; $display("FAIL midrst_after got=%h busy=%0d done=%b want=%h busy=%0d", {cout_o, sum_o}, bc, got, exp, W); end
  endtask

  task automatic test_back_to_back();
    int nd; int last; logic [W:0] exp;
    @(negedge clk_i);
    a_i = 8'h03; b_i = 8'h04; cin_i = 1'b0; start_i = 1'b1;
    for (int k = 0; k < 3; k++) sb_q.push_back({1'b0, a_i} + {1'b0, b_i});
    nd = 0; last = -1;
    for (int cyc = 0; cyc < 60 && nd < 3; cyc++) begin
      @(negedge clk_i);
      if (done_o) begin
        nd++;
        if (sb_q.size() == 0) begin
          checks++; failures++; $display("FAIL b2b_unexpected_done cycle=%0d", cyc);
        end else begin
          exp = sb_q.pop_front();
          checks++; if ({cout_o, sum_o} !== exp) begin failures++; $display("FAIL b2b_result got=%h want=%h", {cout_o, sum_o}, exp); end
        end
        if (last >= 0) begin
          checks++; if (cyc - last != W + 2) begin failures++; $display("FAIL b2b_interval got=%0d want=%0d", cyc - last, W + 2); end
        end
        last = cyc;
      end
    end
    checks++; if (nd != 3) begin failures++; $display("FAIL b2b_done_count got=%0d want=3", nd); end
    rst_i = 1'b1;
    repeat (2) @(negedge clk_i);
    checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL rst_start_accept got_busy=%b want=0", busy_o); end
    rst_i = 1'b0; start_i = 1'b0;
    @(negedge clk_i);
    checks++; if (busy_o !== 1'b0 || done_o !== 1'b0) begin failures++; $display("FAIL rst_start_after got_busy=%b got_done=%b want=0,0", busy_o, done_o); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_carry();
    test_start_while_busy();
    test_operand_hold();
    test_reset_mid();
    test_back_to_back();
    checks++; if (sb_q.size() != 0) begin failures++; $display("FAIL scoreboard_leftover got=%0d want=0", sb_q.size()); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
